// File: rtl/if_fetch_req_ctrl.sv
// Fetch-request sequencer: issues IF fetches on a req/addr_ok/data_ok bus, discards
// responses of flushed fetches and buffers returned packets for the IF register.
module if_fetch_req_ctrl #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              pc_ready_o,
    output logic              inst_req_o,
    output logic [PC_W-1:0]   inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_allowin_i,
    output logic [1:0]        outstanding_o,
    output logic [1:0]        cancel_cnt_o
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR1 = 2'd1,
        CLR2 = 2'd2
    } cancel_state_t;

    cancel_state_t     cancel_q, cancel_d;

    logic [1:0]        outstanding_q;
    logic [1:0]        data_cnt_q;
    logic [2:0]        credit_used;

    logic [PC_W-1:0]   addr_mem [MAX_OUT];
    logic [PTR_W-1:0]  addr_wr_q, addr_rd_q;

    logic [PC_W-1:0]   dpc_mem  [MAX_OUT];
    logic [DATA_W-1:0] ddat_mem [MAX_OUT];
    logic [PTR_W-1:0]  data_wr_q, data_rd_q;

    logic              addr_push;
    logic              resp_valid;
    logic              data_push;
    logic              data_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers in-flight requests plus buffered packets, so a response always has a slot.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, data_cnt_q};
    assign inst_req_o  = pc_valid_i && !flush_i && (credit_used < 3'(MAX_OUT));
    assign inst_addr_o = pc_i;
    assign pc_ready_o  = inst_req_o && inst_addr_ok_i;

    assign addr_push  = pc_ready_o;
    assign resp_valid = inst_data_ok_i && (outstanding_q != '0);
    assign data_push  = resp_valid && (cancel_q == IDLE) && !flush_i;
    assign data_pop   = out_valid_o && out_allowin_i;

    assign out_valid_o   = (data_cnt_q != '0);
    assign out_pc_o      = dpc_mem[data_rd_q];
    assign out_data_o    = ddat_mem[data_rd_q];
    assign outstanding_o = outstanding_q;
    assign cancel_cnt_o  = cancel_q;

    always_ff @(posedge clk) begin
        if (!rst_n) cancel_q <= IDLE;
        else        cancel_q <= cancel_d;
    end

    always_comb begin
        cancel_d = cancel_q;
        if (flush_i) begin
            cancel_d = cancel_state_t'(outstanding_q - {1'b0, resp_valid});
        end else if (resp_valid) begin
            case (cancel_q)
                CLR2:    cancel_d = CLR1;
                CLR1:    cancel_d = IDLE;
                default: cancel_d = cancel_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            addr_wr_q     <= '0;
            addr_rd_q     <= '0;
            data_cnt_q    <= '0;
            data_wr_q     <= '0;
            data_rd_q     <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                addr_mem[i] <= '0;
                dpc_mem[i]  <= '0;
                ddat_mem[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_q + {1'b0, addr_push} - {1'b0, resp_valid};
            if (addr_push) begin
                addr_mem[addr_wr_q] <= pc_i;
                addr_wr_q           <= ptr_inc(addr_wr_q);
            end
            if (resp_valid) addr_rd_q <= ptr_inc(addr_rd_q);

            if (data_push) begin
                dpc_mem[data_wr_q]  <= addr_mem[addr_rd_q];
                ddat_mem[data_wr_q] <= inst_rdata_i;
            end
            // Flush empties the packet buffer, overriding any same-cycle push or pop.
            if (flush_i) begin
                data_cnt_q <= '0;
                data_wr_q  <= '0;
                data_rd_q  <= '0;
            end else begin
                data_cnt_q <= data_cnt_q + {1'b0, data_push} - {1'b0, data_pop};
                if (data_push) data_wr_q <= ptr_inc(data_wr_q);
                if (data_pop)  data_rd_q <= ptr_inc(data_rd_q);
            end
        end
    end

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!rst_n)
        !(inst_data_ok_i && outstanding_q == '0));
    a_cancel_le_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        cancel_q <= outstanding_q);
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_used <= 3'(MAX_OUT));

endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
// Bench for if_fetch_req_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of in-flight requests and buffered packets.
module tb_if_fetch_req_ctrl;

    localparam int PC_W   = 32;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_valid_i;
    logic [PC_W-1:0]   pc_i;
    logic              pc_ready_o;
    logic              inst_req_o;
    logic [PC_W-1:0]   inst_addr_o;
    logic              inst_addr_ok_i;
    logic              inst_data_ok_i;
    logic [DATA_W-1:0] inst_rdata_i;
    logic              flush_i;
    logic              out_valid_o;
    logic [PC_W-1:0]   out_pc_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_allowin_i;
    logic [1:0]        outstanding_o;
    logic [1:0]        cancel_cnt_o;

    always #5 clk = ~clk;

    if_fetch_req_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .MAX_OUT(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_valid_i     (pc_valid_i),
        .pc_i           (pc_i),
        .pc_ready_o     (pc_ready_o),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_pc_o       (out_pc_o),
        .out_data_o     (out_data_o),
        .out_allowin_i  (out_allowin_i),
        .outstanding_o  (outstanding_o),
        .cancel_cnt_o   (cancel_cnt_o)
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        bit                cancelled;
    } fetch_t;

    fetch_t inflight[$];   // accepted by the bus, response not yet returned
    fetch_t pkts[$];       // returned and kept, waiting for the IF register

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_cancelled();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].cancelled) n++;
        return n;
    endfunction

    // Checks the current cycle's outputs, then advances the model across the clock edge.
    task automatic tick();
        bit     exp_req, hs;
        fetch_t e;
        #2;
        exp_req = pc_valid_i && !flush_i && (inflight.size() + pkts.size() < 2);
        check_eq("inst_req", inst_req_o, exp_req);
        check_eq("pc_ready", pc_ready_o, exp_req && inst_addr_ok_i);
        check_eq("inst_addr", inst_addr_o, pc_i);
        check_eq("out_valid", out_valid_o, pkts.size() != 0);
        if (pkts.size() != 0) begin
            check_eq("out_pc", out_pc_o, pkts[0].pc);
            check_eq("out_data", out_data_o, pkts[0].data);
        end
        check_eq("outstanding", outstanding_o, inflight.size());
        check_eq("cancel_cnt", cancel_cnt_o, n_cancelled());
        hs = exp_req && inst_addr_ok_i;
        @(posedge clk);
        if (!rst_n) begin
            inflight.delete();
            pkts.delete();
        end else begin
            if (pkts.size() != 0 && out_allowin_i) void'(pkts.pop_front());
            if (inst_data_ok_i) begin
                e = inflight.pop_front();
                if (!e.cancelled && !flush_i) pkts.push_back(e);
            end
            if (flush_i) begin
                pkts.delete();
                foreach (inflight[i]) inflight[i].cancelled = 1'b1;
            end
            if (hs) inflight.push_back('{pc_i, {$urandom(), $urandom()}, 1'b0});
        end
        #1;
    endtask

    task automatic drive(input bit pv, input logic [PC_W-1:0] pc, input bit aok,
                         input bit dok, input bit fl, input bit allow);
        pc_valid_i     = pv;
        pc_i           = pc;
        inst_addr_ok_i = aok;
        inst_data_ok_i = dok && rst_n && (inflight.size() != 0);
        inst_rdata_i   = inst_data_ok_i ? inflight[0].data : {$urandom(), $urandom()};
        flush_i        = fl;
        out_allowin_i  = allow;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, out_valid_o, 1'b0);
        check_eq({tag, "_out_pc"}, out_pc_o, '0);
        check_eq({tag, "_out_data"}, out_data_o, '0);
        check_eq({tag, "_outstanding"}, outstanding_o, 2'd0);
        check_eq({tag, "_cancel"}, cancel_cnt_o, 2'd0);
    endtask

    initial begin
        logic [PC_W-1:0] pc;
        rst_n = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        rst_n = 1'b1;
        check_reset_outputs("rst0");

        // Zero-wait bus, back-to-back fetches
        drive(1, 32'h1C00_0000, 1, 0, 0, 1);
        drive(1, 32'h1C00_0008, 1, 1, 0, 1);
        drive(0, '0, 0, 1, 0, 1);
        drive(0, '0, 0, 0, 0, 1);
        drive(0, '0, 0, 0, 0, 1);

        // IF register stalled: credit runs out at two
        for (int i = 0; i < 6; i++) drive(1, 32'h1C00_0010 + 32'(i * 8), 1, 1, 0, 0);
        check_eq("stall_req_blocked", inst_req_o, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, '0, 0, 1, 0, 1);

        // Flush with two outstanding and no data_ok
        drive(1, 32'h1C00_0040, 1, 0, 0, 1);
        drive(1, 32'h1C00_0048, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 1, 1);
        check_eq("flush_cancel2", cancel_cnt_o, 2'd2);
        drive(0, '0, 0, 1, 0, 1);
        check_eq("flush_cancel1", cancel_cnt_o, 2'd1);
        drive(0, '0, 0, 1, 0, 1);
        drive(0, '0, 0, 0, 0, 1);

        // Flush coincident with data_ok, then a post-flush fetch
        drive(1, 32'h1C00_0080, 1, 0, 0, 1);
        drive(1, 32'h1C00_0088, 1, 0, 0, 1);
        drive(0, '0, 0, 1, 1, 1);
        check_eq("flush_dok_cancel1", cancel_cnt_o, 2'd1);
        drive(1, 32'h1C00_0100, 1, 0, 0, 1);
        drive(0, '0, 0, 1, 0, 1);
        drive(0, '0, 0, 1, 0, 1);
        check_eq("post_flush_pc", out_pc_o, 32'h1C00_0100);
        drive(0, '0, 0, 0, 0, 1);

        // Second flush while a post-flush fetch is in flight
        drive(1, 32'h1C00_0200, 1, 0, 0, 1);
        drive(1, 32'h1C00_0208, 1, 0, 0, 1);
        drive(0, '0, 0, 1, 1, 1);
        drive(1, 32'h1C00_0300, 1, 0, 0, 1);
        drive(0, '0, 0, 0, 1, 1);
        check_eq("reflush_cancel2", cancel_cnt_o, 2'd2);
        drive(0, '0, 0, 1, 0, 1);
        drive(0, '0, 0, 1, 0, 1);
        drive(0, '0, 0, 0, 0, 1);

        // Reset with the packet buffer full
        drive(1, 32'h1C00_0400, 1, 0, 0, 0);
        drive(1, 32'h1C00_0408, 1, 1, 0, 0);
        drive(0, '0, 0, 1, 0, 0);
        check_eq("full_before_rst", out_valid_o, 1'b1);
        rst_n = 1'b0;
        drive(1, 32'h1C00_0500, 0, 0, 0, 0);
        rst_n = 1'b1;
        check_reset_outputs("rst1");
        drive(0, 32'h1C00_0500, 0, 0, 0, 0);
        drive(1, 32'h1C00_0500, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) rst_n = 1'b0;
            pc = {$urandom_range(32'h0fff), 3'b000} + 32'h1C00_0000;
            drive($urandom_range(3) != 0, pc, $urandom_range(9) < 7, $urandom_range(1) == 1,
                  $urandom_range(11) == 0, $urandom_range(9) < 6);
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
